scratchpad_port_arbiter: RTL and testbench

Two-requester arbiter and lock controller for the single-ported scratchpad (main) memory array. Requester 0 is the system-bus (TileLink-to-scratchpad) side. Requester 1 is the backdoor/debug side, which loads programs and inspects memory without forcing memory pins. The block grants one single-beat access per cycle, returns read data with fixed latency, and lets requester 1 take a timed exclusive lock.

---
 rtl/scratchpad_port_arbiter_if.sv | 26 ++
 rtl/scratchpad_port_arbiter.sv | 133 +++++++++++++
 tb/tb_scratchpad_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratchpad_port_arbiter_if.sv
// One requester port of the scratchpad arbiter: single-beat request
// handshake plus the fixed-latency read response.
interface scratchpad_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    valid;
  logic                    ready;
  logic                    write;
  logic                    lock;
  logic [DATA_WIDTH/8-1:0] mask;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output valid, write, lock, mask, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, lock, mask, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/scratchpad_port_arbiter.sv
// Two-requester round-robin arbiter for the single-ported scratchpad, with a
// timed exclusive lock that requester 1 (debug/backdoor) can take.
module scratchpad_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  scratchpad_port_arbiter_if.slave r0,
  scratchpad_port_arbiter_if.slave r1,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  output logic [ADDR_WIDTH-4:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    lock_active,
  output logic                    lock_timeout
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int WORD_W = ADDR_WIDTH - 3;
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic               last_grant_reg;
  logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic               lock_timeout_reg, lock_timeout_next;
  logic               rvalid_reg;
  logic               owner_reg;
  logic [WORD_W-1:0]  addr_hold_reg;
  logic [DATA_WIDTH-1:0] wdata_hold_reg;

  logic               gnt0, gnt1, any_gnt;
  logic               sel_write;
  logic [MASK_W-1:0]  sel_mask;
  logic [WORD_W-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Byte-offset bits and the r0 lock input have no function here.
  logic unused_bits;
  assign unused_bits = ^{r0.lock, r0.addr[2:0], r1.addr[2:0]};

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (state_reg == LOCKED) begin
        gnt1 = r1.valid;
      end else if (r0.valid && r1.valid) begin
        gnt0 = last_grant_reg;
        gnt1 = !last_grant_reg;
      end else begin
        gnt0 = r0.valid;
        gnt1 = r1.valid;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_write = gnt1 ? r1.write : r0.write;
  assign sel_mask  = gnt1 ? r1.mask  : r0.mask;
  assign sel_addr  = gnt1 ? r1.addr[ADDR_WIDTH-1:3] : r0.addr[ADDR_WIDTH-1:3];
  assign sel_wdata = gnt1 ? r1.wdata : r0.wdata;

  assign r0.ready = gnt0;
  assign r1.ready = gnt1;

  // Address and data buses hold the last granted beat when idle.
  assign mem_write = any_gnt & sel_write;
  assign mem_mask  = (any_gnt && sel_write) ? sel_mask : '0;
  assign mem_addr  = rst ? '0 : (any_gnt ? sel_addr  : addr_hold_reg);
  assign mem_wdata = rst ? '0 : (any_gnt ? sel_wdata : wdata_hold_reg);

  assign r0.rvalid = rvalid_reg & ~owner_reg & ~rst;
  assign r1.rvalid = rvalid_reg &  owner_reg & ~rst;
  assign r0.rdata  = mem_rdata;
  assign r1.rdata  = mem_rdata;

  assign lock_active  = (state_reg == LOCKED) & ~rst;
  assign lock_timeout = lock_timeout_reg & ~rst;

  always_comb begin
    state_next        = state_reg;
    idle_cnt_next     = idle_cnt_reg;
    lock_timeout_next = lock_timeout_reg;
    case (state_reg)
      UNLOCKED: begin
        idle_cnt_next = '0;
        if (gnt1 && r1.lock) state_next = LOCKED;
      end
      LOCKED: begin
        // An r1 accept takes precedence over an expiring idle count.
        if (gnt1) begin
          idle_cnt_next = '0;
          if (!r1.lock) state_next = UNLOCKED;
        end else if (idle_cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_next        = UNLOCKED;
          idle_cnt_next     = '0;
          lock_timeout_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= UNLOCKED;
      last_grant_reg   <= 1'b1;
      idle_cnt_reg     <= '0;
      lock_timeout_reg <= 1'b0;
      rvalid_reg       <= 1'b0;
      owner_reg        <= 1'b0;
      addr_hold_reg    <= '0;
      wdata_hold_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      idle_cnt_reg     <= idle_cnt_next;
      lock_timeout_reg <= lock_timeout_next;
      rvalid_reg       <= any_gnt & ~sel_write;
      if (any_gnt) begin
        last_grant_reg <= gnt1;
        owner_reg      <= gnt1;
        addr_hold_reg  <= sel_addr;
        wdata_hold_reg <= sel_wdata;
      end
    end
  end
endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Bench for scratchpad_port_arbiter: vector table for arbitration and locking,
// hand sequences for timeout, reset and masked writes, read-data scoreboard.
module tb_scratchpad_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scratchpad_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_bus ();
  scratchpad_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_bus ();

  logic          mem_write;
  logic [7:0]    mem_mask;
  logic [AW-4:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          lock_active;
  logic          lock_timeout;

  scratchpad_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .r0(r0_bus), .r1(r1_bus),
    .mem_write(mem_write), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_active(lock_active), .lock_timeout(lock_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hA5A5_0000 | i, 32'h5A5A_0000 | i};
  endfunction

  // Memory array with registered read, plus an independent shadow for expectations.
  logic [63:0] mem [256];
  logic [63:0] shadow [256];
  initial for (int i = 0; i < 256; i++) begin mem[i] = pat(i); shadow[i] = pat(i); end

  always @(posedge clk) begin
    if (mem_write)
      for (int b = 0; b < 8; b++)
        if (mem_mask[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct { logic owner; logic [63:0] data; } exp_t;
  exp_t sb_q[$];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Scoreboard: a read accepted this cycle must return next cycle on the same port.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      chk("rst_rvalid", {r0_bus.rvalid, r1_bus.rvalid}, 2'b00);
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.owner ? "r1_rvalid" : "r0_rvalid", {r1_bus.rvalid, r0_bus.rvalid},
            e.owner ? 2'b10 : 2'b01);
        chk("rdata", e.owner ? r1_bus.rdata : r0_bus.rdata, e.data);
      end else begin
        chk("no_rvalid", {r0_bus.rvalid, r1_bus.rvalid}, 2'b00);
      end
      chk("ready_onehot", r0_bus.ready & r1_bus.ready, 0);
      if (r0_bus.ready) begin
        chk("r0_maddr", mem_addr, r0_bus.addr >> 3);
        chk("r0_mwrite", mem_write, r0_bus.write);
        chk("r0_mmask", mem_mask, r0_bus.write ? r0_bus.mask : 8'h00);
        if (r0_bus.write) shadow[r0_bus.addr[10:3]] = merge(shadow[r0_bus.addr[10:3]], r0_bus.wdata, r0_bus.mask);
        else sb_q.push_back('{owner: 1'b0, data: shadow[r0_bus.addr[10:3]]});
      end
      if (r1_bus.ready) begin
        chk("r1_maddr", mem_addr, r1_bus.addr >> 3);
        chk("r1_mwrite", mem_write, r1_bus.write);
        chk("r1_mmask", mem_mask, r1_bus.write ? r1_bus.mask : 8'h00);
        if (r1_bus.write) shadow[r1_bus.addr[10:3]] = merge(shadow[r1_bus.addr[10:3]], r1_bus.wdata, r1_bus.mask);
        else sb_q.push_back('{owner: 1'b1, data: shadow[r1_bus.addr[10:3]]});
      end
    end
  end

  typedef struct {
    logic v0, w0; logic [31:0] a0; logic [7:0] m0; logic [63:0] d0;
    logic v1, w1, l1; logic [31:0] a1; logic [7:0] m1; logic [63:0] d1;
    logic e_rdy0, e_rdy1, e_lock, e_mwr; logic [7:0] e_mmask; logic [28:0] e_maddr;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, w0, input logic [31:0] a0, input logic [7:0] m0, input logic [63:0] d0,
    input logic v1, w1, l1, input logic [31:0] a1, input logic [7:0] m1, input logic [63:0] d1,
    input logic e_rdy0, e_rdy1, e_lock, e_mwr, input logic [7:0] e_mmask, input logic [28:0] e_maddr);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.m0 = m0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.m1 = m1; v.d1 = d1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_lock = e_lock; v.e_mwr = e_mwr;
    v.e_mmask = e_mmask; v.e_maddr = e_maddr;
    return v;
  endfunction

  task automatic drive0(input logic v, w, input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    r0_bus.valid = v; r0_bus.write = w; r0_bus.addr = a; r0_bus.mask = m; r0_bus.wdata = d;
    r0_bus.lock = 1'b0;
  endtask

  task automatic drive1(input logic v, w, l, input logic [31:0] a, input logic [7:0] m, input logic [63:0] d);
    r1_bus.valid = v; r1_bus.write = w; r1_bus.lock = l; r1_bus.addr = a; r1_bus.mask = m; r1_bus.wdata = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  vec_t vt[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive0(1, 1, 32'h40, 8'hFF, 64'h1234);
    drive1(1, 1, 1, 32'h48, 8'hFF, 64'h5678);

    // Arbitration, write-then-read, and the lock handover sequence.
    vt.push_back(mk(1,0,'h100,'hFF,0, 1,0,0,'h200,'hFF,0, 1,0,0,0,0,'h20));
    vt.push_back(mk(1,0,'h100,'hFF,0, 1,0,0,'h200,'hFF,0, 0,1,0,0,0,'h40));
    vt.push_back(mk(1,0,'h100,'hFF,0, 1,0,0,'h200,'hFF,0, 1,0,0,0,0,'h20));
    vt.push_back(mk(1,0,'h100,'hFF,0, 1,0,0,'h200,'hFF,0, 0,1,0,0,0,'h40));
    vt.push_back(mk(0,0,0,0,0, 1,1,0,'h80,'hFF,64'hDEADBEEF_CAFEF00D, 0,1,0,1,'hFF,'h10));
    vt.push_back(mk(1,0,'h80,'hFF,0, 0,0,0,0,0,0, 1,0,0,0,0,'h10));
    vt.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,'h10));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,1,'h200,0,0, 0,1,0,0,0,'h40));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,1,'h208,0,0, 0,1,1,0,0,'h41));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,1,'h210,0,0, 0,1,1,0,0,'h42));
    vt.push_back(mk(1,0,'h100,0,0, 0,0,0,0,0,0, 0,0,1,0,0,'h42));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,1,'h218,0,0, 0,1,1,0,0,'h43));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,0,'h220,0,0, 0,1,1,0,0,'h44));
    vt.push_back(mk(1,0,'h100,0,0, 0,0,0,0,0,0, 1,0,0,0,0,'h20));
    vt.push_back(mk(1,0,'h100,0,0, 1,0,0,'h200,0,0, 0,1,0,0,0,'h40));

    // Reset state, with both requesters trying to write.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {r0_bus.ready, r1_bus.ready}, 2'b00);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_mask", mem_mask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_lock", {lock_active, lock_timeout}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      drive0(vt[i].v0, vt[i].w0, vt[i].a0, vt[i].m0, vt[i].d0);
      drive1(vt[i].v1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].m1, vt[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {r0_bus.ready, r1_bus.ready}, {vt[i].e_rdy0, vt[i].e_rdy1});
      chk($sformatf("v%0d_lock_active", i), lock_active, vt[i].e_lock);
      chk($sformatf("v%0d_mem_write", i), mem_write, vt[i].e_mwr);
      chk($sformatf("v%0d_mem_mask", i), mem_mask, vt[i].e_mmask);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].e_maddr);
      tick();
    end

    // Lock, then an r1 accept in the cycle the idle count would expire, then a real timeout.
    drive0(0, 0, 0, 0, 0);
    drive1(1, 0, 1, 32'h300, 0, 0);
    @(negedge clk); chk("to_lock_accept", r1_bus.ready, 1);
    tick();
    drive0(1, 0, 32'h108, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= LT - 1; k++) begin
      @(negedge clk);
      chk($sformatf("to_a%0d_state", k), {lock_active, r0_bus.ready, lock_timeout}, 3'b100);
      tick();
    end
    drive1(1, 0, 1, 32'h308, 0, 0);
    @(negedge clk);
    chk("to_accept_wins", {lock_active, r1_bus.ready, r0_bus.ready, lock_timeout}, 4'b1100);
    tick();
    drive1(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= LT; k++) begin
      @(negedge clk);
      chk($sformatf("to_b%0d_state", k), {lock_active, r0_bus.ready, lock_timeout}, 3'b100);
      tick();
    end
    @(negedge clk);
    chk("to_release", {lock_active, r0_bus.ready, lock_timeout}, 3'b011);
    tick();
    drive0(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("to_sticky", {lock_active, lock_timeout}, 2'b01);
      tick();
    end

    // Reset the cycle after an r0 read accept.
    drive0(1, 0, 32'h110, 0, 0);
    @(negedge clk); chk("rr_accept", r0_bus.ready, 1);
    tick();
    rst = 1'b1;
    drive0(1, 1, 32'h118, 8'hFF, 64'h99);
    drive1(1, 1, 0, 32'h120, 8'hFF, 64'h77);
    @(negedge clk);
    chk("rr_rvalid", r0_bus.rvalid, 0);
    chk("rr_ready", {r0_bus.ready, r1_bus.ready}, 2'b00);
    chk("rr_mem", {mem_write, mem_mask}, 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_mem_wdata", mem_wdata, 0);
    chk("rr_lock", {lock_active, lock_timeout}, 2'b00);
    tick();
    rst = 1'b0;
    drive0(1, 0, 32'h100, 0, 0);
    drive1(1, 0, 0, 32'h200, 0, 0);
    @(negedge clk); chk("rr_first_tie", {r0_bus.ready, r1_bus.ready}, 2'b10);
    tick();

    // Masked write, idle hold, then read back the merged word.
    drive0(1, 1, 32'h08, 8'h0F, 64'h1111_2222_3333_4444);
    drive1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_beat", {r0_bus.ready, mem_write, mem_mask}, {2'b11, 8'h0F});
    chk("mw_addr", mem_addr, 1);
    tick();
    drive0(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mw_idle", {mem_write, mem_mask}, 0);
      chk("mw_hold_addr", mem_addr, 1);
      tick();
    end
    drive1(1, 0, 0, 32'h08, 0, 0);
    @(negedge clk); chk("mw_readback_accept", r1_bus.ready, 1);
    tick();
    drive1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_merged", r1_bus.rdata, {32'hA5A5_0001, 32'h3333_4444});
    tick();
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
